alu_op_sequencer: RTL and testbench
===================================

// Module: alu_op_sequencer
// PURPOSE
//  Sits between decode/issue and the RV32IM ALU in the execute stage. Accepts one op at a time,
//  owns the ALU operand/control registers, holds them stable for the 32-step sequential divider,
//  pulses alu_op_valid, waits out alu_busy, and returns a registered result with backpressure.
//  Also provides the pipeline stall source (issue_ready) and flush handling.
// PARAMETERS
//  DIV_STEPS   32  divider iterations; DIV_WAIT watchdog limit is DIV_STEPS+2 cycles
// PORTS
//  clk            in   1   clock, all state on posedge
//  reset          in   1   synchronous, active-high
//  flush          in   1   abort in-flight op, no writeback
//  issue_valid    in   1   op presented
//  issue_ready    out  1   op accepted when valid&ready
//  issue_funct3   in   3   instr[14:12]
//  issue_instr_30 in   1   instr[30] (SUB/SRA)
//  issue_instr_5  in   1   instr[5] (R-type vs imm)
//  issue_is_m     in   1   M-extension op (funct7==1, OP)
//  issue_in1      in   32  rs1 value
//  issue_in2      in   32  rs2 value or immediate
//  issue_rd       in   5   destination register
//  alu_op_valid   out  1   one-cycle divider start strobe
//  alu_funct3     out  3   registered funct3
//  alu_instr_30   out  1   registered
//  alu_instr_5    out  1   registered
//  alu_is_mul_div out  1   = is_m
//  alu_is_divide  out  1   is_m & funct3[2]
//  alu_is_rem     out  1   is_m & funct3[2] & funct3[1]
//  alu_is_unsigned out 1   is_m & funct3[2] & funct3[0]
//  alu_in1/alu_in2 out 32  registered operands
//  alu_busy       in   1   divider busy
//  alu_out        in   32  ALU result (combinational)
//  wb_valid       out  1   result available
//  wb_ready       in   1   writeback accepts
//  wb_rd          out  5   destination
//  wb_data        out  32  result
//  err_div_timeout out 1   sticky: divider exceeded watchdog
// BEHAVIOUR
//  Reset: state=IDLE; issue_ready=1; alu_op_valid=0; wb_valid=0; err_div_timeout=0; all alu_* ctl/data
//   and wb_rd/wb_data = 0. ALU divider regs are unreset; next alu_op_valid reloads them.
//  issue_ready = !flush & (IDLE | (DONE & wb_ready)). On accept: latch all issue_* into alu_*/rd regs.
//  FSM: IDLE -accept,!div-> EXEC; IDLE -accept,div-> DIV_START.
//   EXEC (1 cyc): wb_data<=alu_out -> DONE.
//   DIV_START (1 cyc): alu_op_valid=1, cnt<=0 -> DIV_WAIT. busy is NOT sampled here.
//   DIV_WAIT: cnt++; when alu_busy==0 -> wb_data<=alu_out -> DONE. If cnt reaches DIV_STEPS+2 with
//    busy still 1: set err_div_timeout, capture alu_out anyway -> DONE.
//   DONE: wb_valid=1, wb_rd/wb_data held stable until wb_ready. wb_ready&accept -> EXEC/DIV_START
//    (back-to-back); wb_ready&!accept -> IDLE.
//  Latency accept-edge -> wb_valid: non-divide 2 cycles; divide DIV_STEPS+3 cycles (35).
//  alu_in1/in2/control held constant from accept until leaving DONE (divider reads in1/in2 sign live).
//  Divide by zero / overflow: no special case; ALU arithmetic gives RISC-V results (q=all-ones,
//   r=dividend; 0x80000000/-1 = 0x80000000, rem 0).
//  flush: any state -> IDLE next cycle, wb_valid=0, no accept that cycle, err flag unchanged;
//   flush overrides wb_ready. Abandoned divider keeps shifting harmlessly.
//  reset mid-divide: same as flush plus err cleared. rd==0 ops still produce wb_valid.
// STRUCTURE
//  Shared include (alu_defs.vh): FSM state encoding (IDLE,EXEC,DIV_START,DIV_WAIT,DONE), funct3
//   constants (ADD..AND, MUL..REMU). No sub-module; the ALU is a sibling instance in execute,
//   wired by the parent. Watchdog counter is $clog2(DIV_STEPS+3) bits.
// TESTING
//  ADD in1=5 in2=7 f3=0 i30=0 -> wb_valid 2 cyc after accept, wb_data=12, issue_ready low until taken
//  SUB i30=1 i5=1 in1=3 in2=5 -> 0xFFFFFFFE; MULHU 0xFFFFFFFF*0xFFFFFFFF -> 0xFFFFFFFE at 2 cycles
//  DIV -7/2 -> 0xFFFFFFFD, REM -7/2 -> 0xFFFFFFFF, each wb_valid exactly 35 cyc after accept
//  DIVU 0x1234/0 -> 0xFFFFFFFF; REMU 0x1234/0 -> 0x1234; DIV 0x80000000/-1 -> 0x80000000
//  flush 10 cycles into DIV -> no wb_valid, IDLE next cycle; following ADD 1+1 -> 2 in 2 cycles
//  wb_ready low 3 cycles in DONE -> wb_data/wb_rd stable, issue_ready=0; then back-to-back accept

Source files
------------

// File: rtl/alu_op_sequencer_pkg.sv
// alu_op_sequencer_pkg
//   Shared definitions for the execute-stage ALU op sequencer:
//   - FSM state encoding (IDLE, EXEC, DIV_START, DIV_WAIT, DONE)
//   - RV32I / RV32M funct3 constants
//   - default divider iteration count
//   - small decode helpers used by the sequencer
package alu_op_sequencer_pkg;

  // Number of iterations the sequential divider needs per operation.
  localparam int DIV_STEPS_DEFAULT = 32;

  // Sequencer states.
  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_EXEC      = 3'd1,
    ST_DIV_START = 3'd2,
    ST_DIV_WAIT  = 3'd3,
    ST_DONE      = 3'd4
  } seq_state_e;

  // RV32I OP/OP-IMM funct3 encodings.
  localparam logic [2:0] F3_ADD  = 3'b000;
  localparam logic [2:0] F3_SLL  = 3'b001;
  localparam logic [2:0] F3_SLT  = 3'b010;
  localparam logic [2:0] F3_SLTU = 3'b011;
  localparam logic [2:0] F3_XOR  = 3'b100;
  localparam logic [2:0] F3_SRL  = 3'b101;
  localparam logic [2:0] F3_OR   = 3'b110;
  localparam logic [2:0] F3_AND  = 3'b111;

  // RV32M funct3 encodings.
  localparam logic [2:0] F3_MUL    = 3'b000;
  localparam logic [2:0] F3_MULH   = 3'b001;
  localparam logic [2:0] F3_MULHSU = 3'b010;
  localparam logic [2:0] F3_MULHU  = 3'b011;
  localparam logic [2:0] F3_DIV    = 3'b100;
  localparam logic [2:0] F3_DIVU   = 3'b101;
  localparam logic [2:0] F3_REM    = 3'b110;
  localparam logic [2:0] F3_REMU   = 3'b111;

  // Every M-extension op with funct3[2] set goes through the sequential divider.
  function automatic logic is_div_op(input logic is_m, input logic [2:0] funct3);
    return is_m & funct3[2];
  endfunction

  // Remainder variants (REM/REMU) of the divider ops.
  function automatic logic is_rem_op(input logic is_m, input logic [2:0] funct3);
    return is_m & funct3[2] & funct3[1];
  endfunction

  // Unsigned variants (DIVU/REMU) of the divider ops.
  function automatic logic is_unsigned_div_op(input logic is_m, input logic [2:0] funct3);
    return is_m & funct3[2] & funct3[0];
  endfunction

endpackage

// File: rtl/alu_op_sequencer.sv
// alu_op_sequencer
//   Sits between decode/issue and the RV32IM ALU in the execute stage.
//   Accepts one op at a time, owns the ALU operand/control registers and
//   keeps them stable while the sequential divider runs, strobes
//   alu_op_valid to start a divide, waits out alu_busy (with a watchdog),
//   and returns a registered result through a valid/ready writeback port.
//
// Ports
//   clk, reset                 clock and synchronous active-high reset
//   flush                      abort in-flight op, no writeback
//   issue_valid / issue_ready  op handshake (issue_ready is the stall source)
//   issue_funct3, issue_instr_30, issue_instr_5, issue_is_m
//                              decoded op fields
//   issue_in1, issue_in2       rs1 value, rs2 value or immediate
//   issue_rd                   destination register
//   alu_op_valid               one-cycle divider start strobe
//   alu_funct3 .. alu_is_unsigned, alu_in1, alu_in2
//                              registered control/operands to the ALU
//   alu_busy, alu_out          divider busy and combinational ALU result
//   wb_valid / wb_ready        result handshake
//   wb_rd, wb_data             destination register and result
//   err_div_timeout            sticky: divider exceeded the watchdog limit
module alu_op_sequencer
  import alu_op_sequencer_pkg::*;
#(
  parameter int DIV_STEPS = DIV_STEPS_DEFAULT
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        flush,

  input  logic        issue_valid,
  output logic        issue_ready,
  input  logic [2:0]  issue_funct3,
  input  logic        issue_instr_30,
  input  logic        issue_instr_5,
  input  logic        issue_is_m,
  input  logic [31:0] issue_in1,
  input  logic [31:0] issue_in2,
  input  logic [4:0]  issue_rd,

  output logic        alu_op_valid,
  output logic [2:0]  alu_funct3,
  output logic        alu_instr_30,
  output logic        alu_instr_5,
  output logic        alu_is_mul_div,
  output logic        alu_is_divide,
  output logic        alu_is_rem,
  output logic        alu_is_unsigned,
  output logic [31:0] alu_in1,
  output logic [31:0] alu_in2,
  input  logic        alu_busy,
  input  logic [31:0] alu_out,

  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,

  output logic        err_div_timeout
);

  // Watchdog counter is wide enough to reach DIV_STEPS+2.
  localparam int CNT_W = $clog2(DIV_STEPS + 3);
  localparam logic [CNT_W-1:0] CNT_LIMIT = CNT_W'(DIV_STEPS + 2);

  seq_state_e       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;

  logic [2:0]       funct3_q, funct3_d;
  logic             instr_30_q, instr_30_d;
  logic             instr_5_q, instr_5_d;
  logic             is_m_q, is_m_d;
  logic [31:0]      in1_q, in1_d;
  logic [31:0]      in2_q, in2_d;
  logic [4:0]       rd_q, rd_d;

  logic [31:0]      wb_data_q, wb_data_d;
  logic             err_q, err_d;

  logic             accept;
  logic             accept_is_div;

  // Stall source: a new op can only enter when nothing is in flight, or when
  // the finished result is leaving this very cycle. Flush blocks intake.
  always_comb begin
    issue_ready   = !flush && ((state_q == ST_IDLE) ||
                               ((state_q == ST_DONE) && wb_ready));
    accept        = issue_valid && issue_ready;
    accept_is_div = is_div_op(issue_is_m, issue_funct3);
  end

  // Next-state logic. Operand/control registers only change on accept, so
  // the divider sees stable inputs from start until the result is taken.
  // Flush wins over everything and leaves the sticky error flag alone.
  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    funct3_d   = funct3_q;
    instr_30_d = instr_30_q;
    instr_5_d  = instr_5_q;
    is_m_d     = is_m_q;
    in1_d      = in1_q;
    in2_d      = in2_q;
    rd_d       = rd_q;
    wb_data_d  = wb_data_q;
    err_d      = err_q;

    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          state_d = accept_is_div ? ST_DIV_START : ST_EXEC;
        end
      end

      ST_EXEC: begin
        wb_data_d = alu_out;
        state_d   = ST_DONE;
      end

      // The divider only latches its operands here; busy is meaningless
      // until the next cycle, so it is not looked at.
      ST_DIV_START: begin
        cnt_d   = '0;
        state_d = ST_DIV_WAIT;
      end

      // A stuck divider must not hang the pipeline: after the watchdog
      // limit the current ALU output is taken as-is and the error latched.
      ST_DIV_WAIT: begin
        if (!alu_busy) begin
          wb_data_d = alu_out;
          state_d   = ST_DONE;
        end else if (cnt_q == CNT_LIMIT) begin
          wb_data_d = alu_out;
          err_d     = 1'b1;
          state_d   = ST_DONE;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end

      ST_DONE: begin
        if (accept) begin
          state_d = accept_is_div ? ST_DIV_START : ST_EXEC;
        end else if (wb_ready) begin
          state_d = ST_IDLE;
        end
      end

      default: begin
        state_d = ST_IDLE;
      end
    endcase

    if (accept) begin
      funct3_d   = issue_funct3;
      instr_30_d = issue_instr_30;
      instr_5_d  = issue_instr_5;
      is_m_d     = issue_is_m;
      in1_d      = issue_in1;
      in2_d      = issue_in2;
      rd_d       = issue_rd;
    end

    if (flush) begin
      state_d   = ST_IDLE;
      wb_data_d = wb_data_q;
      err_d     = err_q;
    end
  end

  // State and datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      funct3_q   <= '0;
      instr_30_q <= 1'b0;
      instr_5_q  <= 1'b0;
      is_m_q     <= 1'b0;
      in1_q      <= '0;
      in2_q      <= '0;
      rd_q       <= '0;
      wb_data_q  <= '0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      funct3_q   <= funct3_d;
      instr_30_q <= instr_30_d;
      instr_5_q  <= instr_5_d;
      is_m_q     <= is_m_d;
      in1_q      <= in1_d;
      in2_q      <= in2_d;
      rd_q       <= rd_d;
      wb_data_q  <= wb_data_d;
      err_q      <= err_d;
    end
  end

  // ALU-facing control is decoded from the held op fields.
  always_comb begin
    alu_op_valid    = (state_q == ST_DIV_START);
    alu_funct3      = funct3_q;
    alu_instr_30    = instr_30_q;
    alu_instr_5     = instr_5_q;
    alu_is_mul_div  = is_m_q;
    alu_is_divide   = is_div_op(is_m_q, funct3_q);
    alu_is_rem      = is_rem_op(is_m_q, funct3_q);
    alu_is_unsigned = is_unsigned_div_op(is_m_q, funct3_q);
    alu_in1         = in1_q;
    alu_in2         = in2_q;
  end

  // Writeback side.
  always_comb begin
    wb_valid        = (state_q == ST_DONE);
    wb_rd           = rd_q;
    wb_data         = wb_data_q;
    err_div_timeout = err_q;
  end

endmodule

// File: tb/tb_alu_op_sequencer.sv
// tb_alu_op_sequencer
//   Directed bench for alu_op_sequencer. A behavioural RV32IM ALU sibling
//   supplies alu_out combinationally and models a 32-step divider whose
//   busy can be forced stuck to exercise the watchdog.
module tb_alu_op_sequencer;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        flush = 1'b0;
  logic        issue_valid = 1'b0;
  logic        issue_ready;
  logic [2:0]  issue_funct3 = '0;
  logic        issue_instr_30 = 1'b0;
  logic        issue_instr_5 = 1'b0;
  logic        issue_is_m = 1'b0;
  logic [31:0] issue_in1 = '0;
  logic [31:0] issue_in2 = '0;
  logic [4:0]  issue_rd = '0;
  logic        alu_op_valid;
  logic [2:0]  alu_funct3;
  logic        alu_instr_30;
  logic        alu_instr_5;
  logic        alu_is_mul_div;
  logic        alu_is_divide;
  logic        alu_is_rem;
  logic        alu_is_unsigned;
  logic [31:0] alu_in1;
  logic [31:0] alu_in2;
  logic        alu_busy;
  logic [31:0] alu_out;
  logic        wb_valid;
  logic        wb_ready = 1'b1;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        err_div_timeout;

  int checks = 0;
  int errors = 0;

  alu_op_sequencer dut (
    .clk(clk), .reset(reset), .flush(flush),
    .issue_valid(issue_valid), .issue_ready(issue_ready),
    .issue_funct3(issue_funct3), .issue_instr_30(issue_instr_30),
    .issue_instr_5(issue_instr_5), .issue_is_m(issue_is_m),
    .issue_in1(issue_in1), .issue_in2(issue_in2), .issue_rd(issue_rd),
    .alu_op_valid(alu_op_valid), .alu_funct3(alu_funct3),
    .alu_instr_30(alu_instr_30), .alu_instr_5(alu_instr_5),
    .alu_is_mul_div(alu_is_mul_div), .alu_is_divide(alu_is_divide),
    .alu_is_rem(alu_is_rem), .alu_is_unsigned(alu_is_unsigned),
    .alu_in1(alu_in1), .alu_in2(alu_in2),
    .alu_busy(alu_busy), .alu_out(alu_out),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_rd(wb_rd), .wb_data(wb_data),
    .err_div_timeout(err_div_timeout)
  );

  always #5 clk = ~clk;

  // Divider busy model: a start strobe loads 32 steps of busy.
  int   div_cnt = 0;
  logic stuck_busy = 1'b0;

  always @(posedge clk) begin
    if (alu_op_valid) div_cnt <= 32;
    else if (div_cnt > 0) div_cnt <= div_cnt - 1;
  end

  assign alu_busy = (div_cnt != 0) || stuck_busy;

  // RV32IM reference arithmetic for the ALU sibling.
  logic [63:0] prod;
  always_comb begin
    prod    = 64'd0;
    alu_out = 32'd0;
    if (alu_is_mul_div) begin
      case (alu_funct3)
        3'b000: begin prod = {32'd0, alu_in1} * {32'd0, alu_in2}; alu_out = prod[31:0]; end
        3'b001: begin prod = {{32{alu_in1[31]}}, alu_in1} * {{32{alu_in2[31]}}, alu_in2}; alu_out = prod[63:32]; end
        3'b010: begin prod = {{32{alu_in1[31]}}, alu_in1} * {32'd0, alu_in2}; alu_out = prod[63:32]; end
        3'b011: begin prod = {32'd0, alu_in1} * {32'd0, alu_in2}; alu_out = prod[63:32]; end
        3'b100: begin
          if (alu_in2 == 0) alu_out = 32'hFFFF_FFFF;
          else if (alu_in1 == 32'h8000_0000 && alu_in2 == 32'hFFFF_FFFF) alu_out = 32'h8000_0000;
          else alu_out = $signed(alu_in1) / $signed(alu_in2);
        end
        3'b101: alu_out = (alu_in2 == 0) ? 32'hFFFF_FFFF : alu_in1 / alu_in2;
        3'b110: begin
          if (alu_in2 == 0) alu_out = alu_in1;
          else if (alu_in1 == 32'h8000_0000 && alu_in2 == 32'hFFFF_FFFF) alu_out = 32'd0;
          else alu_out = $signed(alu_in1) % $signed(alu_in2);
        end
        default: alu_out = (alu_in2 == 0) ? alu_in1 : alu_in1 % alu_in2;
      endcase
    end else begin
      case (alu_funct3)
        3'b000: alu_out = (alu_instr_30 && alu_instr_5) ? alu_in1 - alu_in2 : alu_in1 + alu_in2;
        3'b001: alu_out = alu_in1 << alu_in2[4:0];
        3'b010: alu_out = {31'd0, $signed(alu_in1) < $signed(alu_in2)};
        3'b011: alu_out = {31'd0, alu_in1 < alu_in2};
        3'b100: alu_out = alu_in1 ^ alu_in2;
        3'b101: alu_out = alu_instr_30 ? 32'($signed(alu_in1) >>> alu_in2[4:0]) : alu_in1 >> alu_in2[4:0];
        3'b110: alu_out = alu_in1 | alu_in2;
        default: alu_out = alu_in1 & alu_in2;
      endcase
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=0x%08h expected=0x%08h", tag, observed, expected);
    end
  endtask

  // Present an op, confirm it can be taken, and let one edge accept it.
  // Returns one cycle after the accept edge.
  task automatic applyStimulus(input string tag, input logic [2:0] f3, input logic i30,
                               input logic i5, input logic is_m, input logic [31:0] in1,
                               input logic [31:0] in2, input logic [4:0] rd);
    issue_funct3   = f3;
    issue_instr_30 = i30;
    issue_instr_5  = i5;
    issue_is_m     = is_m;
    issue_in1      = in1;
    issue_in2      = in2;
    issue_rd       = rd;
    issue_valid    = 1'b1;
    #1;
    checkOutput({tag, " issue_ready"}, {31'd0, issue_ready}, 32'd1);
    step();
    issue_valid = 1'b0;
    #1;
  endtask

  // Wait (bounded) for wb_valid and check latency and result.
  task automatic waitResult(input string tag, input int start_lat, input int exp_lat,
                            input logic [31:0] exp_data, input logic [4:0] exp_rd);
    int lat;
    lat = start_lat;
    while (wb_valid !== 1'b1 && lat < 60) begin
      step();
      lat++;
    end
    checkOutput({tag, " latency"}, lat, exp_lat);
    checkOutput({tag, " wb_data"}, wb_data, exp_data);
    checkOutput({tag, " wb_rd"}, {27'd0, wb_rd}, {27'd0, exp_rd});
  endtask

  initial begin
    $display("[TB] start");
    step();
    step();
    reset = 1'b0;
    #1;
    checkOutput("rst issue_ready", {31'd0, issue_ready}, 32'd1);
    checkOutput("rst wb_valid", {31'd0, wb_valid}, 32'd0);
    checkOutput("rst alu_op_valid", {31'd0, alu_op_valid}, 32'd0);
    checkOutput("rst err", {31'd0, err_div_timeout}, 32'd0);
    checkOutput("rst alu_in1", alu_in1, 32'd0);
    checkOutput("rst alu_funct3", {29'd0, alu_funct3}, 32'd0);
    checkOutput("rst wb_data", wb_data, 32'd0);

    // ADD 5+7: issue_ready low while executing.
    applyStimulus("add", 3'b000, 1'b0, 1'b1, 1'b0, 32'd5, 32'd7, 5'd1);
    checkOutput("add exec issue_ready", {31'd0, issue_ready}, 32'd0);
    checkOutput("add exec wb_valid", {31'd0, wb_valid}, 32'd0);
    waitResult("add", 1, 2, 32'd12, 5'd1);
    step();

    // SUB 3-5.
    applyStimulus("sub", 3'b000, 1'b1, 1'b1, 1'b0, 32'd3, 32'd5, 5'd2);
    waitResult("sub", 1, 2, 32'hFFFF_FFFE, 5'd2);
    step();

    // MULHU all-ones squared.
    applyStimulus("mulhu", 3'b011, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3);
    checkOutput("mulhu no start", {31'd0, alu_op_valid}, 32'd0);
    waitResult("mulhu", 1, 2, 32'hFFFF_FFFE, 5'd3);
    step();

    // OR with rd=0 still writes back.
    applyStimulus("or rd0", 3'b110, 1'b0, 1'b1, 1'b0, 32'h0000_F000, 32'h0000_000F, 5'd0);
    waitResult("or rd0", 1, 2, 32'h0000_F00F, 5'd0);
    step();

    // DIV -7/2.
    applyStimulus("div", 3'b100, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 5'd4);
    checkOutput("div start strobe", {31'd0, alu_op_valid}, 32'd1);
    checkOutput("div is_divide", {31'd0, alu_is_divide}, 32'd1);
    checkOutput("div is_rem", {31'd0, alu_is_rem}, 32'd0);
    checkOutput("div is_unsigned", {31'd0, alu_is_unsigned}, 32'd0);
    checkOutput("div alu_in1", alu_in1, 32'hFFFF_FFF9);
    waitResult("div", 1, 35, 32'hFFFF_FFFD, 5'd4);
    checkOutput("div alu_in2 held", alu_in2, 32'd2);
    step();

    // REM -7/2.
    applyStimulus("rem", 3'b110, 1'b0, 1'b1, 1'b1, 32'hFFFF_FFF9, 32'd2, 5'd5);
    step();
    checkOutput("rem strobe one cycle", {31'd0, alu_op_valid}, 32'd0);
    checkOutput("rem is_rem", {31'd0, alu_is_rem}, 32'd1);
    waitResult("rem", 2, 35, 32'hFFFF_FFFF, 5'd5);
    step();

    // Divide by zero and overflow.
    applyStimulus("divu0", 3'b101, 1'b0, 1'b1, 1'b1, 32'h0000_1234, 32'd0, 5'd6);
    checkOutput("divu0 is_unsigned", {31'd0, alu_is_unsigned}, 32'd1);
    waitResult("divu0", 1, 35, 32'hFFFF_FFFF, 5'd6);
    step();
    applyStimulus("remu0", 3'b111, 1'b0, 1'b1, 1'b1, 32'h0000_1234, 32'd0, 5'd7);
    waitResult("remu0", 1, 35, 32'h0000_1234, 5'd7);
    step();
    applyStimulus("divovf", 3'b100, 1'b0, 1'b1, 1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 5'd8);
    waitResult("divovf", 1, 35, 32'h8000_0000, 5'd8);
    step();

    // Flush 10 cycles into a divide.
    applyStimulus("flush div", 3'b100, 1'b0, 1'b1, 1'b1, 32'd100, 32'd7, 5'd3);
    for (int i = 0; i < 9; i++) step();
    flush = 1'b1;
    issue_valid = 1'b1;
    #1;
    checkOutput("flush issue_ready", {31'd0, issue_ready}, 32'd0);
    step();
    flush = 1'b0;
    issue_valid = 1'b0;
    #1;
    checkOutput("flush wb_valid", {31'd0, wb_valid}, 32'd0);
    checkOutput("flush idle ready", {31'd0, issue_ready}, 32'd1);
    checkOutput("flush err", {31'd0, err_div_timeout}, 32'd0);
    for (int i = 0; i < 3; i++) begin
      step();
      checkOutput("flush no wb", {31'd0, wb_valid}, 32'd0);
    end
    applyStimulus("add after flush", 3'b000, 1'b0, 1'b1, 1'b0, 32'd1, 32'd1, 5'd10);
    waitResult("add after flush", 1, 2, 32'd2, 5'd10);
    step();

    // Backpressure: hold result, then back-to-back accept.
    wb_ready = 1'b0;
    applyStimulus("stall add", 3'b000, 1'b0, 1'b1, 1'b0, 32'd10, 32'd20, 5'd9);
    waitResult("stall add", 1, 2, 32'd30, 5'd9);
    issue_funct3   = 3'b100;
    issue_instr_30 = 1'b0;
    issue_instr_5  = 1'b1;
    issue_is_m     = 1'b0;
    issue_in1      = 32'h0000_F0F0;
    issue_in2      = 32'h0000_0FF0;
    issue_rd       = 5'd4;
    issue_valid    = 1'b1;
    for (int i = 0; i < 3; i++) begin
      #1;
      checkOutput("stall wb_valid", {31'd0, wb_valid}, 32'd1);
      checkOutput("stall wb_data", wb_data, 32'd30);
      checkOutput("stall wb_rd", {27'd0, wb_rd}, 32'd9);
      checkOutput("stall issue_ready", {31'd0, issue_ready}, 32'd0);
      step();
    end
    wb_ready = 1'b1;
    #1;
    checkOutput("b2b issue_ready", {31'd0, issue_ready}, 32'd1);
    step();
    issue_valid = 1'b0;
    #1;
    checkOutput("b2b wb_valid drop", {31'd0, wb_valid}, 32'd0);
    checkOutput("b2b alu_in1", alu_in1, 32'h0000_F0F0);
    waitResult("b2b xor", 1, 2, 32'h0000_FF00, 5'd4);
    step();

    // Watchdog: divider busy stuck high.
    stuck_busy = 1'b1;
    applyStimulus("timeout", 3'b101, 1'b0, 1'b1, 1'b1, 32'd100, 32'd10, 5'd11);
    waitResult("timeout", 1, 37, 32'd10, 5'd11);
    checkOutput("timeout err", {31'd0, err_div_timeout}, 32'd1);
    stuck_busy = 1'b0;
    step();
    applyStimulus("sticky add", 3'b111, 1'b0, 1'b1, 1'b0, 32'h0000_00FF, 32'h0000_0F0F, 5'd12);
    waitResult("sticky add", 1, 2, 32'h0000_000F, 5'd12);
    checkOutput("sticky err", {31'd0, err_div_timeout}, 32'd1);
    step();

    // Reset in the middle of a divide.
    applyStimulus("reset div", 3'b100, 1'b0, 1'b1, 1'b1, 32'd50, 32'd5, 5'd13);
    for (int i = 0; i < 5; i++) step();
    reset = 1'b1;
    step();
    reset = 1'b0;
    #1;
    checkOutput("mid rst err", {31'd0, err_div_timeout}, 32'd0);
    checkOutput("mid rst wb_valid", {31'd0, wb_valid}, 32'd0);
    checkOutput("mid rst issue_ready", {31'd0, issue_ready}, 32'd1);
    checkOutput("mid rst alu_in1", alu_in1, 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
